multicycle_control_unit: RTL
============================

MULTICYCLE_CONTROL_UNIT -- requirements
Module: multicycle_control_unit

Interface
REQ-001 Parameter OPCODE_W, default 4, SHALL set opcode width (legal range 4..8); opcodes decode on bits [3:0], upper bits SHALL be zero for legal instructions.
REQ-002 Parameter ALUOP_W, default 3, SHALL set aluop width (minimum 3); encodings zero-extended.
REQ-003 clk  input  1  SHALL be the single clock; all state updates on the rising edge.
REQ-004 rst  input  1  SHALL be the asynchronous, active-high reset.
REQ-005 opcode  input  OPCODE_W  SHALL carry the instruction opcode, sampled only on the fetch handshake.
REQ-006 instr_valid  input  1  SHALL indicate the opcode is valid.
REQ-007 instr_ready  output  1  SHALL indicate the unit accepts an opcode this cycle.
REQ-008 mem_ready  input  1  SHALL indicate completion of the current memory access.
REQ-009 branch, regdst, alusrc, regwrite, memread, memreg, memwrite  output  1 each  SHALL be the datapath controls.
REQ-010 aluop  output  ALUOP_W  SHALL be the ALU operation select.
REQ-011 busy  output  1  SHALL be high in DECODE, EXEC, MEM and WB.
REQ-012 illegal  output  1  SHALL flag an illegal-opcode trap.

Function
REQ-013 States SHALL be IDLE, FETCH, DECODE, EXEC, MEM, WB, TRAP; state and the latched opcode SHALL be registers; all outputs SHALL be decoded from these registers only, with no input-to-output combinational path.
REQ-014 IDLE -> FETCH unconditionally one cycle after reset release.
REQ-015 FETCH: instr_ready=1; on instr_valid=1, opcode latched and -> DECODE; otherwise hold FETCH.
REQ-016 Opcodes: 0=R-type, 1=ADDI, 4=BEQ, 8=LW, 9=SW; all others are illegal.
REQ-017 DECODE: all controls 0; legal -> EXEC; illegal handled per REQ-029/030.
REQ-018 EXEC: R-type regdst=1, aluop=2; ADDI/LW/SW alusrc=1, aluop=0; BEQ branch=1 for exactly one cycle, aluop=1, -> FETCH; R-type/ADDI -> WB; LW/SW -> MEM.
REQ-019 MEM: memread=1 (LW) or memwrite=1 (SW), alusrc=1 held until mem_ready=1; then LW -> WB, SW -> FETCH; no timeout.
REQ-020 WB: regwrite=1 for exactly one cycle; memreg=1 for LW only; regdst=1 for R-type only; -> FETCH.
REQ-021 Latency from fetch-handshake cycle back to the next FETCH: BEQ 3 cycles, R-type/ADDI/SW 4 cycles, LW 5 cycles, with mem_ready already high; each mem_ready-low cycle adds 1.
REQ-022 memread and memwrite SHALL never be high together; regwrite and memwrite SHALL never be high together.
REQ-023 instr_ready SHALL be 0 in every state except FETCH; instr_valid outside FETCH SHALL be ignored.
REQ-024 mem_ready outside MEM SHALL be ignored.

Reset
REQ-025 While rst=1, state SHALL be IDLE, the latched opcode 0, and every output 0, including instr_ready, busy and illegal.
REQ-026 rst asserted mid-instruction, including MEM with memread/memwrite high, SHALL drive all outputs 0 immediately without waiting for a clock edge.
REQ-027 No partial instruction SHALL resume after reset; the next instruction is fetched fresh.

Configuration
REQ-028 Macro CTRL_ILLEGAL_TRAP_EN SHALL select illegal-opcode handling.
REQ-029 Defined: illegal opcode, DECODE -> TRAP; TRAP holds illegal=1, busy=0, instr_ready=0 and all other controls 0 until reset.
REQ-030 Undefined: TRAP state SHALL be absent; illegal opcode, DECODE -> FETCH as a NOP (2-cycle latency); illegal tied 0.

Structure
REQ-031 Package ctrl_pkg SHALL hold the state enum, opcode constants (OP_RTYPE, OP_ADDI, OP_BEQ, OP_LW, OP_SW) and aluop constants (ALU_ADD=0, ALU_SUB=1, ALU_FUNCT=2).
REQ-032 Combinational sub-module ctrl_opdecode SHALL map the latched opcode to instruction class and legal flag; the FSM and output decode SHALL reside in multicycle_control_unit.

Verification
REQ-033 Reset, then opcode=0 with instr_valid=1 -> handshake at FETCH, regdst=1/aluop=2 in EXEC, regwrite=1 one cycle in WB, instr_ready again 4 cycles after handshake.
REQ-034 opcode=8, mem_ready low 3 cycles -> memread=1 for 4 cycles, then regwrite=1 and memreg=1 for one cycle; total latency 8.
REQ-035 opcode=9, mem_ready=1 -> memwrite=1 one cycle, regwrite never 1, back to FETCH after 4 cycles.
REQ-036 opcode=4 -> branch=1 exactly one cycle; regwrite/memread/memwrite stay 0; next FETCH 3 cycles after handshake.
REQ-037 opcode=15: with CTRL_ILLEGAL_TRAP_EN -> illegal=1, instr_ready stuck 0 until rst; without -> illegal=0, FETCH 2 cycles after handshake.
REQ-038 rst pulsed asynchronously between clock edges during MEM of LW -> memread falls before the next edge, state IDLE, then FETCH one cycle after release.

Source files
------------

// File: rtl/ctrl_pkg.sv
// Shared types and constants for the multicycle control unit.
// Optional feature: CTRL_ILLEGAL_TRAP_EN adds the TRAP state for illegal opcodes.
package ctrl_pkg;

  // FSM states; TRAP only exists when illegal-opcode trapping is enabled.
  typedef enum logic [2:0] {
    StIdle   = 3'd0,
    StFetch  = 3'd1,
    StDecode = 3'd2,
    StExec   = 3'd3,
    StMem    = 3'd4,
`ifdef CTRL_ILLEGAL_TRAP_EN
    StWb     = 3'd5,
    StTrap   = 3'd6
`else
    StWb     = 3'd5
`endif
  } state_e;

  // Instruction classes produced by the opcode decoder.
  typedef enum logic [2:0] {
    ClsRtype   = 3'd0,
    ClsAddi    = 3'd1,
    ClsBeq     = 3'd2,
    ClsLw      = 3'd3,
    ClsSw      = 3'd4,
    ClsIllegal = 3'd5
  } instr_class_e;

  // Opcode encodings (bits [3:0]; any higher opcode bits must be zero).
  localparam logic [3:0] OP_RTYPE = 4'd0;
  localparam logic [3:0] OP_ADDI  = 4'd1;
  localparam logic [3:0] OP_BEQ   = 4'd4;
  localparam logic [3:0] OP_LW    = 4'd8;
  localparam logic [3:0] OP_SW    = 4'd9;

  // ALU operation selects, zero-extended to the aluop port width.
  localparam logic [2:0] ALU_ADD   = 3'd0;
  localparam logic [2:0] ALU_SUB   = 3'd1;
  localparam logic [2:0] ALU_FUNCT = 3'd2;

endpackage

// File: rtl/ctrl_opdecode.sv
// Combinational opcode decoder: latched opcode -> instruction class and legal flag.
module ctrl_opdecode
  import ctrl_pkg::*;
#(
  parameter int unsigned OPCODE_W = 4
) (
  input  logic [OPCODE_W-1:0] opcode_i,
  output instr_class_e        cls_o,
  output logic                legal_o
);

  logic upper_zero;

  // Shift rather than slice so OPCODE_W == 4 needs no special case.
  assign upper_zero = ((opcode_i >> 4) == '0);

  // Classify the opcode; anything unlisted or with high bits set is illegal.
  always_comb begin
    cls_o = ClsIllegal;
    if (upper_zero) begin
      case (opcode_i[3:0])
        OP_RTYPE: cls_o = ClsRtype;
        OP_ADDI:  cls_o = ClsAddi;
        OP_BEQ:   cls_o = ClsBeq;
        OP_LW:    cls_o = ClsLw;
        OP_SW:    cls_o = ClsSw;
        default:  cls_o = ClsIllegal;
      endcase
    end
    legal_o = (cls_o != ClsIllegal);
  end

endmodule

// File: rtl/multicycle_control_unit.sv
// Multicycle datapath controller: IDLE/FETCH/DECODE/EXEC/MEM/WB FSM.
// Outputs decode only from state_q and opcode_q, so async reset clears them at once.
// Optional feature: define CTRL_ILLEGAL_TRAP_EN to trap on illegal opcodes
// (otherwise illegal opcodes retire as a NOP from DECODE).
module multicycle_control_unit
  import ctrl_pkg::*;
#(
  parameter int unsigned OPCODE_W = 4,
  parameter int unsigned ALUOP_W  = 3
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [OPCODE_W-1:0] opcode,
  input  logic                instr_valid,
  output logic                instr_ready,
  input  logic                mem_ready,
  output logic                branch,
  output logic                regdst,
  output logic                alusrc,
  output logic                regwrite,
  output logic                memread,
  output logic                memreg,
  output logic                memwrite,
  output logic [ALUOP_W-1:0]  aluop,
  output logic                busy,
  output logic                illegal
);

  state_e              state_q, state_d;
  logic [OPCODE_W-1:0] opcode_q, opcode_d;
  instr_class_e        cls;
  logic                legal;

  ctrl_opdecode #(
    .OPCODE_W (OPCODE_W)
  ) u_opdecode (
    .opcode_i (opcode_q),
    .cls_o    (cls),
    .legal_o  (legal)
  );

  // Next-state and opcode-latch logic.
  always_comb begin
    state_d  = state_q;
    opcode_d = opcode_q;
    case (state_q)
      StIdle: state_d = StFetch;
      StFetch: begin
        if (instr_valid) begin
          opcode_d = opcode;
          state_d  = StDecode;
        end
      end
      StDecode: begin
        if (legal) begin
          state_d = StExec;
        end else begin
`ifdef CTRL_ILLEGAL_TRAP_EN
          state_d = StTrap;
`else
          state_d = StFetch;
`endif
        end
      end
      StExec: begin
        case (cls)
          ClsRtype, ClsAddi: state_d = StWb;
          ClsLw, ClsSw:      state_d = StMem;
          default:           state_d = StFetch;
        endcase
      end
      StMem: begin
        if (mem_ready) begin
          state_d = (cls == ClsLw) ? StWb : StFetch;
        end
      end
      StWb: state_d = StFetch;
`ifdef CTRL_ILLEGAL_TRAP_EN
      StTrap: state_d = StTrap;
`endif
      default: state_d = StIdle;
    endcase
  end

  // State and latched opcode registers with asynchronous reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= StIdle;
      opcode_q <= '0;
    end else begin
      state_q  <= state_d;
      opcode_q <= opcode_d;
    end
  end

  // Output decode from registered state and latched opcode only.
  always_comb begin
    instr_ready = 1'b0;
    branch      = 1'b0;
    regdst      = 1'b0;
    alusrc      = 1'b0;
    regwrite    = 1'b0;
    memread     = 1'b0;
    memreg      = 1'b0;
    memwrite    = 1'b0;
    aluop       = ALUOP_W'(ALU_ADD);
    busy        = 1'b0;
    illegal     = 1'b0;
    case (state_q)
      StFetch:  instr_ready = 1'b1;
      StDecode: busy = 1'b1;
      StExec: begin
        busy = 1'b1;
        case (cls)
          ClsRtype: begin
            regdst = 1'b1;
            aluop  = ALUOP_W'(ALU_FUNCT);
          end
          ClsAddi, ClsLw, ClsSw: begin
            alusrc = 1'b1;
            aluop  = ALUOP_W'(ALU_ADD);
          end
          ClsBeq: begin
            branch = 1'b1;
            aluop  = ALUOP_W'(ALU_SUB);
          end
          default: ;
        endcase
      end
      StMem: begin
        busy     = 1'b1;
        alusrc   = 1'b1;
        memread  = (cls == ClsLw);
        memwrite = (cls == ClsSw);
      end
      StWb: begin
        busy     = 1'b1;
        regwrite = 1'b1;
        memreg   = (cls == ClsLw);
        regdst   = (cls == ClsRtype);
      end
`ifdef CTRL_ILLEGAL_TRAP_EN
      StTrap: illegal = 1'b1;
`endif
      default: ;
    endcase
  end

endmodule
